rr_priority_arbiter: RTL

- Registered, parametrised N-port arbiter built around two combinational priority encoders.
- Supports fixed-priority or round-robin selection, with optional grant holding by request or by acknowledge.
- Sits in front of shared resources such as AXI interconnect address channels and mux select paths.
- Produces a one-hot grant, the encoded grant index and a valid flag, all from flops.

---
 rtl/arb_pkg.sv | 14 +
 rtl/rr_priority_arbiter_if.sv | 33 +++
 rtl/rr_priority_arbiter_enc.sv | 32 +++
 rtl/rr_priority_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin / fixed-priority arbiter.
// Holds the hold-mode encodings and the index-width helper.
package arb_pkg;

  localparam int ARB_BLOCK_NONE    = 0;
  localparam int ARB_BLOCK_REQUEST = 1;
  localparam int ARB_BLOCK_ACK     = 2;

  // Index width for an n-entry vector, never narrower than one bit.
  function automatic int arb_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master = requester side, slave = arbiter side.
interface rr_priority_arbiter_if
  import arb_pkg::*;
#(
  parameter int PORTS = 4
) ();

  localparam int IW = arb_idx_w(PORTS);

  logic [PORTS-1:0] request;
  logic [PORTS-1:0] acknowledge;
  logic [PORTS-1:0] grant;
  logic             grant_valid;
  logic [IW-1:0]    grant_encoded;

  modport master (
    output request,
    output acknowledge,
    input  grant,
    input  grant_valid,
    input  grant_encoded
  );

  modport slave (
    input  request,
    input  acknowledge,
    output grant,
    output grant_valid,
    output grant_encoded
  );

endinterface

// File: rtl/rr_priority_arbiter_enc.sv
// Combinational priority encoder: reports whether any input bit is set and
// the index of the winning bit (lowest index first when LSB_HIGH_PRIORITY=1,
// highest index first otherwise).
module rr_priority_arbiter_enc
  import arb_pkg::*;
#(
  parameter int WIDTH             = 4,
  parameter int LSB_HIGH_PRIORITY = 1
) (
  input  logic [WIDTH-1:0]            req_i,
  output logic                        valid_o,
  output logic [arb_idx_w(WIDTH)-1:0] idx_o
);

  localparam int IW = arb_idx_w(WIDTH);

  // Scan so that the highest-priority set bit is the last one written.
  always_comb begin
    valid_o = |req_i;
    idx_o   = '0;
    if (LSB_HIGH_PRIORITY != 0) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req_i[i]) idx_o = i[IW-1:0];
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req_i[i]) idx_o = i[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-port arbiter, fixed priority or round robin, with optional
// grant holding by request level or by acknowledge pulse.
// Optional feature: define ARBITER_HOLD_LIMIT_EN to force a release after
// MAX_HOLD held cycles; without it a held grant is kept indefinitely.
module rr_priority_arbiter
  import arb_pkg::*;
#(
  parameter int PORTS             = 4,
  parameter int ARB_ROUND_ROBIN   = 1,
  parameter int ARB_BLOCK         = 0,
  parameter int LSB_HIGH_PRIORITY = 1,
  parameter int MAX_HOLD          = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  rr_priority_arbiter_if.slave  bus
);

  localparam int IW = arb_idx_w(PORTS);

  // State is implied by grant_valid: no grant means idle.
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_GRANTED = 1'b1;

  logic [PORTS-1:0] grant_q, grant_d;
  logic             grant_valid_q, grant_valid_d;
  logic [IW-1:0]    grant_enc_q, grant_enc_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [PORTS-1:0] mask_eff;

  logic             u_valid, m_valid;
  logic [IW-1:0]    u_idx, m_idx;
  logic             win_valid;
  logic [IW-1:0]    win_idx;

  logic [0:0]       state;
  logic             held_release;
  logic             limit_hit;
  logic             arbitrate;

  // Fixed mode ignores the rotation mask entirely.
  assign mask_eff = (ARB_ROUND_ROBIN != 0) ? mask_q : {PORTS{1'b1}};
  assign state    = grant_valid_q ? ST_GRANTED : ST_IDLE;

  rr_priority_arbiter_enc #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_enc_u (
    .req_i   (bus.request),
    .valid_o (u_valid),
    .idx_o   (u_idx)
  );

  rr_priority_arbiter_enc #(
    .WIDTH             (PORTS),
    .LSB_HIGH_PRIORITY (LSB_HIGH_PRIORITY)
  ) u_enc_m (
    .req_i   (bus.request & mask_eff),
    .valid_o (m_valid),
    .idx_o   (m_idx)
  );

  // Masked winner continues the rotation; unmasked winner restarts it.
  always_comb begin
    win_valid = u_valid;
    win_idx   = m_valid ? m_idx : u_idx;
  end

  // Decide whether the current holder lets go this cycle.
  always_comb begin
    held_release = 1'b1;
    case (ARB_BLOCK)
      ARB_BLOCK_REQUEST: held_release = ~bus.request[grant_enc_q];
      ARB_BLOCK_ACK:     held_release = bus.acknowledge[grant_enc_q];
      default:           held_release = 1'b1;
    endcase
  end

`ifdef ARBITER_HOLD_LIMIT_EN
  localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_cnt_q, hold_cnt_d;

  // The cycle whose count would reach MAX_HOLD is the last held cycle.
  always_comb begin
    limit_hit = (ARB_BLOCK != ARB_BLOCK_NONE) &&
                ((int'(hold_cnt_q) + 1) >= MAX_HOLD);
    hold_cnt_d = hold_cnt_q;
    if (arbitrate) begin
      hold_cnt_d = '0;
    end else if (grant_valid_q && (ARB_BLOCK != ARB_BLOCK_NONE)) begin
      hold_cnt_d = hold_cnt_q + 1'b1;
    end
  end

  // Hold counter register, cleared on reset and on every new grant.
  always_ff @(posedge clk) begin
    if (rst) hold_cnt_q <= '0;
    else     hold_cnt_q <= hold_cnt_d;
  end
`else
  assign limit_hit = 1'b0;
`endif

  // Idle arbitrates every cycle; granted arbitrates only on release.
  always_comb begin
    case (state)
      ST_IDLE:    arbitrate = 1'b1;
      ST_GRANTED: arbitrate = held_release | limit_hit;
      default:    arbitrate = 1'b1;
    endcase
  end

  // Next grant, index and rotation mask.
  always_comb begin
    grant_d       = grant_q;
    grant_valid_d = grant_valid_q;
    grant_enc_d   = grant_enc_q;
    mask_d        = mask_q;
    if (arbitrate) begin
      grant_valid_d = win_valid;
      grant_d       = '0;
      if (win_valid) begin
        grant_d[win_idx] = 1'b1;
        grant_enc_d      = win_idx;
        for (int j = 0; j < PORTS; j++) begin
          if (LSB_HIGH_PRIORITY != 0) mask_d[j] = (j > int'(win_idx));
          else                        mask_d[j] = (j < int'(win_idx));
        end
      end
    end
  end

  // Output and mask registers; reset wins over any hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      grant_enc_q   <= '0;
      mask_q        <= {PORTS{1'b1}};
    end else begin
      grant_q       <= grant_d;
      grant_valid_q <= grant_valid_d;
      grant_enc_q   <= grant_enc_d;
      mask_q        <= mask_d;
    end
  end

  assign bus.grant         = grant_q;
  assign bus.grant_valid   = grant_valid_q;
  assign bus.grant_encoded = grant_enc_q;

endmodule
